// File: rtl/unidade_multdiv_param.sv
// Iterative multiply/divide unit with HI/LO registers (shift-add MULT, restoring DIV).
// Define MULTDIV_MTHI_MTLO_EN to add MTHI/MTLO (codes 1110/1111) writes from op_a.
module unidade_multdiv_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ULAopcode,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OpMult = 4'b1000;
  localparam logic [3:0] OpDiv  = 4'b1001;
  localparam logic [3:0] OpMflo = 4'b1010;
  localparam logic [3:0] OpMfhi = 4'b1011;
`ifdef MULTDIV_MTHI_MTLO_EN
  localparam logic [3:0] OpMthi = 4'b1110;
  localparam logic [3:0] OpMtlo = 4'b1111;
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // MULT: {partial, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opb_mag;
  logic [WIDTH-1:0]   hi, lo;
  logic               is_div, neg_q, neg_r, dz;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, acc_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign a_neg = ~Unsigned & op_a[WIDTH-1];
  assign b_neg = ~Unsigned & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // One radix-2 step of either algorithm on the shared accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_mag} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_mag};
    if (is_div) begin
      if (div_diff[WIDTH]) begin
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX; divide-by-zero bypasses it.
  always_comb begin
    acc_neg = -acc;
    fix_hi  = acc[2*WIDTH-1:WIDTH];
    fix_lo  = acc[WIDTH-1:0];
    if (!dz) begin
      if (is_div) begin
        if (neg_q) fix_lo = -acc[WIDTH-1:0];
        if (neg_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
      end else if (neg_q) begin
        fix_hi = acc_neg[2*WIDTH-1:WIDTH];
        fix_lo = acc_neg[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      acc      <= '0;
      opb_mag  <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            case (ULAopcode)
              OpMult: begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                opb_mag <= b_mag;
                is_div  <= 1'b0;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= 1'b0;
                dz      <= 1'b0;
                cnt     <= CNT_W'(WIDTH);
                busy    <= 1'b1;
                state   <= StCalc;
              end
              OpDiv: begin
                is_div <= 1'b1;
                busy   <= 1'b1;
                if (op_b == '0) begin
                  acc      <= {op_a, {WIDTH{1'b1}}};
                  dz       <= 1'b1;
                  neg_q    <= 1'b0;
                  neg_r    <= 1'b0;
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                  state    <= StFix;
                end else begin
                  acc     <= {{WIDTH{1'b0}}, a_mag};
                  opb_mag <= b_mag;
                  dz      <= 1'b0;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                  cnt     <= CNT_W'(WIDTH);
                  state   <= StCalc;
                end
              end
`ifdef MULTDIV_MTHI_MTLO_EN
              OpMthi: begin
                hi   <= op_a;
                done <= 1'b1;
              end
              OpMtlo: begin
                lo   <= op_a;
                done <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        StCalc: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= StFix;
          end
        end
        StFix: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (ULAopcode == OpMfhi) begin
      result = hi;
    end else if (ULAopcode == OpMflo) begin
      result = lo;
    end
  end

endmodule

// File: tb/tb_unidade_multdiv_param.sv
// Bench for unidade_multdiv_param: arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_unidade_multdiv_param;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ULAopcode = 4'b0000;
  logic         Unsigned = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] result;
  logic         busy, done, div_zero;

  unidade_multdiv_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ULAopcode(ULAopcode), .Unsigned(Unsigned),
    .op_a(op_a), .op_b(op_b), .result(result), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: returns {div_zero, hi, lo} computed with plain integer arithmetic.
  function automatic logic [2*W:0] ref_op(input logic [3:0] op, input logic u,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'b1000) begin
      if (u) p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      else   p = sa * sb;
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (u) return {1'b0, a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Model: m_rem counts remaining busy cycles; results land when it leaves 1.
  int           m_rem;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         p_dz, m_mt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_dz  <= 1'b0;
      m_mt  <= 1'b0;
    end else begin
      m_mt <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end else if (start && (ULAopcode == 4'b1000 || ULAopcode == 4'b1001)) begin
        {p_dz, p_hi, p_lo} <= ref_op(ULAopcode, Unsigned, op_a, op_b);
        m_rem <= (ULAopcode == 4'b1001 && op_b == '0) ? 1 : int'(W) + 1;
      end
`ifdef MULTDIV_MTHI_MTLO_EN
      else if (start && ULAopcode == 4'b1110) begin
        m_hi <= op_a;
        m_mt <= 1'b1;
      end else if (start && ULAopcode == 4'b1111) begin
        m_lo <= op_a;
        m_mt <= 1'b1;
      end
`endif
    end
  end

  int           n_tests = 0;
  int           n_fail = 0;
  logic         lit_valid = 1'b0;
  logic [W-1:0] lit_exp = '0;
  string        lit_name = "";

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] exp_res;
    exp_res = (ULAopcode == 4'b1011) ? m_hi : (ULAopcode == 4'b1010) ? m_lo : '0;
    chk("busy", W'(busy), W'(m_rem != 0));
    chk("done", W'(done), W'(m_rem == 1 || m_mt));
    chk("div_zero", W'(div_zero), W'(m_rem == 1 && p_dz));
    chk("result", result, exp_res);
    if (lit_valid) chk(lit_name, result, lit_exp);
  end

  // Called at posedge+1; leaves the bench at posedge+1 after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic u, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start = 1'b1; ULAopcode = op; Unsigned = u; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; ULAopcode = 4'b0000;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (m_rem == 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic lit(input logic [3:0] op, input logic [W-1:0] exp, input string name);
    start = 1'b0; ULAopcode = op; lit_exp = exp; lit_name = name; lit_valid = 1'b1;
    @(posedge clk); #1;
    lit_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    lit(4'b1010, 32'h0, "lo_after_reset");

    do_op(4'b1000, 1'b0, 32'hFFFF_FFFD, 32'd5); wait_idle();
    lit(4'b1011, 32'hFFFF_FFFF, "smult_hi");
    lit(4'b1010, 32'hFFFF_FFF1, "smult_lo");
    do_op(4'b1000, 1'b1, 32'hFFFF_FFFD, 32'd5); wait_idle();
    lit(4'b1011, 32'h0000_0004, "umult_hi");
    lit(4'b1010, 32'hFFFF_FFF1, "umult_lo");

    do_op(4'b1000, 1'b0, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    lit(4'b1010, 32'h0, "lo_after_abort");
    lit(4'b1011, 32'h0, "hi_after_abort");

    do_op(4'b1001, 1'b0, 32'hFFFF_FFF9, 32'd2); wait_idle();
    lit(4'b1010, 32'hFFFF_FFFD, "sdiv_lo");
    lit(4'b1011, 32'hFFFF_FFFF, "sdiv_hi");

    do_op(4'b1001, 1'b0, 32'h0000_1234, 32'd0); wait_idle();
    lit(4'b1010, 32'hFFFF_FFFF, "dz_lo");
    lit(4'b1011, 32'h0000_1234, "dz_hi");

    do_op(4'b1000, 1'b0, 32'd3, 32'd4);
    repeat (8) @(posedge clk);
    #1;
    do_op(4'b1001, 1'b0, 32'd100, 32'd7);
    wait_idle();
    do_op(4'b1001, 1'b0, 32'd100, 32'd7);
    lit(4'b1010, 32'd12, "mult_lo_held_while_busy");
    wait_idle();
    lit(4'b1010, 32'd14, "div_lo");
    lit(4'b1011, 32'd2, "div_hi");

    do_op(4'b1001, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    lit(4'b1010, 32'h8000_0000, "ovf_lo");
    lit(4'b1011, 32'h0, "ovf_hi");

    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 9) < 3);
      Unsigned = 1'($urandom_range(0, 1));
      op_a     = pick();
      op_b     = pick();
      case ($urandom_range(0, 4))
        0:       ULAopcode = 4'b1000;
        1:       ULAopcode = 4'b1001;
        2:       ULAopcode = 4'b1010;
        3:       ULAopcode = 4'b1011;
        default: ULAopcode = 4'($urandom);
      endcase
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    start = 1'b0;
    wait_idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
